lzc_feeder: RTL and testbench

Upstream feeder and result collector for the LZC block. It accepts one wide operand (WIDTH*WORD bits) through a valid/ready handshake and serializes it MSB-word-first onto LZC's IVALID/DATA/MODE inputs. It then waits for LZC's OVALID/ZEROS and returns the count through a second valid/ready handshake. Only one operand is in flight at a time; a timeout guards against a missing OVALID.

---
 rtl/lzc_pkg.sv | 23 ++
 rtl/lzc_feeder_if.sv | 36 +++
 rtl/lzc_feeder.sv | 105 ++++++++++
 tb/tb_lzc_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared types and helpers for the LZC feeder: FSM state encoding, count width
// and a constant-foldable ceil-log2.
package lzc_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int ZW = 6;

   // Never returns less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/lzc_feeder_if.sv
// Operand, LZC-side and result handshakes of the feeder bundled as one bus.
// slave is the feeder's view; master is the view of everything around it.
interface lzc_feeder_if
   import lzc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int WORD  = 4
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH*WORD-1:0]   in_data;
   logic                    in_mode;

   logic                    ivalid;
   logic [WIDTH-1:0]        data;
   logic                    mode;
   logic                    ovalid;
   logic [ZW-1:0]           zeros;

   logic                    res_valid;
   logic                    res_ready;
   logic [ZW-1:0]           res_zeros;
   logic                    res_err;

   modport slave (
      input  in_valid, in_data, in_mode, ovalid, zeros, res_ready,
      output in_ready, ivalid, data, mode, res_valid, res_zeros, res_err
   );

   modport master (
      output in_valid, in_data, in_mode, ovalid, zeros, res_ready,
      input  in_ready, ivalid, data, mode, res_valid, res_zeros, res_err
   );

endinterface

// File: rtl/lzc_feeder.sv
// Serializes one wide operand MSB-word-first into LZC and returns its count,
// or an error flag if LZC never answers within TIMEOUT cycles.
module lzc_feeder
   import lzc_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int WORD    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   lzc_feeder_if.slave  bus
);

   localparam int OPW = WIDTH * WORD;
   localparam int WCW = clog2(WORD);
   localparam int TCW = clog2(TIMEOUT);

   state_t           state, state_nxt;
   logic [OPW-1:0]   sreg;
   logic [WCW-1:0]   wcnt;
   logic [TCW-1:0]   tcnt;
   logic             last_word;
   logic             timed_out;

   assign last_word = (wcnt == WCW'(WORD - 1));
   assign timed_out = (tcnt == TCW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.in_valid)                state_nxt = S_SEND;
         S_SEND: if (last_word)                   state_nxt = S_WAIT;
         S_WAIT: if (bus.ovalid || timed_out)     state_nxt = S_DONE;
         S_DONE: if (bus.res_ready)               state_nxt = S_IDLE;
         default:                                 state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state == S_IDLE);
   end

   // DATA is registered, so the first word is loaded straight from the operand
   // and sreg keeps only the words still to be sent, already left-aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg          <= '0;
         wcnt          <= '0;
         tcnt          <= '0;
         bus.ivalid    <= 1'b0;
         bus.data      <= '0;
         bus.mode      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_zeros <= '0;
         bus.res_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  sreg       <= bus.in_data << WIDTH;
                  bus.data   <= bus.in_data[OPW-1 -: WIDTH];
                  bus.ivalid <= 1'b1;
                  bus.mode   <= bus.in_mode;
                  wcnt       <= '0;
               end
            end
            S_SEND: begin
               if (last_word) begin
                  bus.ivalid <= 1'b0;
                  tcnt       <= '0;
               end else begin
                  bus.data <= sreg[OPW-1 -: WIDTH];
                  sreg     <= sreg << WIDTH;
                  wcnt     <= wcnt + WCW'(1);
               end
            end
            S_WAIT: begin
               // A real answer on the final timeout cycle still beats the error.
               if (bus.ovalid) begin
                  bus.res_zeros <= bus.zeros;
                  bus.res_err   <= 1'b0;
                  bus.res_valid <= 1'b1;
               end else if (timed_out) begin
                  bus.res_zeros <= '0;
                  bus.res_err   <= 1'b1;
                  bus.res_valid <= 1'b1;
               end else begin
                  tcnt <= tcnt + TCW'(1);
               end
            end
            S_DONE: begin
               if (bus.res_ready) bus.res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lzc_feeder.sv
// Directed bench for lzc_feeder; the bench itself plays the LZC and the consumer.
module tb_lzc_feeder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   seen;
   int   acc [3];

   logic [31:0] opd [3];
   logic        opm [3];
   logic [5:0]  opz [3];

   lzc_feeder_if #(.WIDTH(8), .WORD(4)) bus ();

   lzc_feeder #(.WIDTH(8), .WORD(4), .TIMEOUT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers an operand, waits for the accept, and checks all four words.
   // Returns in the cycle showing the last word.
   task automatic feed(input logic [31:0] d, input logic m, input bit spur);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("acc_rdy", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      for (int w = 0; w < 4; w++) begin
         chk("ivalid", {31'd0, bus.ivalid}, 32'd1);
         chk("word", {24'd0, bus.data}, {24'd0, d[31-8*w -: 8]});
         chk("mode", {31'd0, bus.mode}, {31'd0, m});
         if (spur && w == 1) begin
            bus.ovalid = 1'b1;
            bus.zeros  = 6'd5;
         end else begin
            bus.ovalid = 1'b0;
         end
         if (w < 3) tick();
      end
   endtask

   task automatic release_res();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("rel_idle", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      bus.ovalid    = 1'b0;
      bus.zeros     = '0;
      bus.res_ready = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_ivalid", {31'd0, bus.ivalid}, 32'd0);
      chk("rst_data", {24'd0, bus.data}, 32'd0);
      chk("rst_mode", {31'd0, bus.mode}, 32'd0);
      chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("rst_res_zeros", {26'd0, bus.res_zeros}, 32'd0);
      chk("rst_res_err", {31'd0, bus.res_err}, 32'd0);
      rst = 1'b0;
      tick();

      // reset in the middle of SEND, on the second word
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA1B2_C3D4;
      bus.in_mode  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("mr_w0", {24'd0, bus.data}, 32'h0000_00A1);
      tick();
      chk("mr_w1", {24'd0, bus.data}, 32'h0000_00B2);
      #2 rst = 1'b1;
      #1;
      chk("mr_ivalid_async", {31'd0, bus.ivalid}, 32'd0);
      chk("mr_mode_async", {31'd0, bus.mode}, 32'd0);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.res_valid || bus.ivalid) seen = 1'b1;
         tick();
      end
      chk("mr_no_activity", {31'd0, seen}, 32'd0);
      chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // basic: 00,00,1F,FF -> 19
      feed(32'h0000_1FFF, 1'b0, 1'b0);
      tick();
      chk("b_ivalid_off", {31'd0, bus.ivalid}, 32'd0);
      chk("b_data_hold", {24'd0, bus.data}, 32'h0000_00FF);
      bus.ovalid = 1'b1;
      bus.zeros  = 6'd19;
      chk("b_res_early", {31'd0, bus.res_valid}, 32'd0);
      tick();
      bus.ovalid = 1'b0;
      chk("b_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("b_res_zeros", {26'd0, bus.res_zeros}, 32'd19);
      chk("b_res_err", {31'd0, bus.res_err}, 32'd0);
      chk("b_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      release_res();

      // backpressure on the result, second operand held upstream
      feed(32'h0F00_0000, 1'b1, 1'b0);
      tick();
      bus.ovalid = 1'b1;
      bus.zeros  = 6'd4;
      tick();
      bus.ovalid   = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      bus.in_mode  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
         chk("bp_res_zeros", {26'd0, bus.res_zeros}, 32'd4);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_ivalid", {31'd0, bus.ivalid}, 32'd0);
         tick();
      end
      bus.res_ready = 1'b1;
      chk("bp_last_valid", {31'd0, bus.res_valid}, 32'd1);
      tick();
      bus.res_ready = 1'b0;
      chk("bp_res_drop", {31'd0, bus.res_valid}, 32'd0);
      chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
      chk("bp_not_taken", {31'd0, bus.ivalid}, 32'd0);
      tick();
      bus.in_valid = 1'b0;
      chk("bp2_ivalid", {31'd0, bus.ivalid}, 32'd1);
      chk("bp2_w0", {24'd0, bus.data}, 32'h0000_00FF);
      chk("bp2_mode", {31'd0, bus.mode}, 32'd0);
      tick(); tick(); tick();
      tick();
      bus.ovalid = 1'b1;
      bus.zeros  = 6'd0;
      tick();
      bus.ovalid = 1'b0;
      chk("bp2_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("bp2_res_zeros", {26'd0, bus.res_zeros}, 32'd0);
      release_res();

      // pure timeout: WAIT entry at cycle 5, result from cycle 69
      feed(32'h1234_5678, 1'b1, 1'b0);
      tick();
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (bus.res_valid) seen = 1'b1;
         tick();
      end
      chk("to_early", {31'd0, seen}, 32'd0);
      chk("to_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("to_res_err", {31'd0, bus.res_err}, 32'd1);
      chk("to_res_zeros", {26'd0, bus.res_zeros}, 32'd0);
      release_res();

      // spurious OVALID in SEND, real OVALID on the last timeout cycle
      feed(32'h0000_00FF, 1'b0, 1'b1);
      tick();
      seen = 1'b0;
      for (int i = 0; i < 63; i++) begin
         if (bus.res_valid) seen = 1'b1;
         tick();
      end
      chk("co_spur_ignored", {31'd0, seen}, 32'd0);
      chk("co_pre_valid", {31'd0, bus.res_valid}, 32'd0);
      bus.ovalid = 1'b1;
      bus.zeros  = 6'd24;
      tick();
      bus.ovalid = 1'b0;
      chk("co_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("co_res_err", {31'd0, bus.res_err}, 32'd0);
      chk("co_res_zeros", {26'd0, bus.res_zeros}, 32'd24);
      release_res();

      // back-to-back with IN_VALID and RES_READY held high
      opd[0] = 32'h0000_0001; opm[0] = 1'b0; opz[0] = 6'd31;
      opd[1] = 32'h0000_0000; opm[1] = 1'b1; opz[1] = 6'd32;
      opd[2] = 32'hFFFF_0000; opm[2] = 1'b1; opz[2] = 6'd0;
      bus.res_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = opd[0];
      bus.in_mode   = opm[0];
      for (int k = 0; k < 3; k++) begin
         chk("bb_rdy", {31'd0, bus.in_ready}, 32'd1);
         acc[k] = cyc;
         tick();
         if (k < 2) begin
            bus.in_data = opd[k+1];
            bus.in_mode = opm[k+1];
         end else begin
            bus.in_valid = 1'b0;
         end
         for (int w = 0; w < 4; w++) begin
            chk("bb_ivalid", {31'd0, bus.ivalid}, 32'd1);
            chk("bb_word", {24'd0, bus.data}, {24'd0, opd[k][31-8*w -: 8]});
            chk("bb_mode", {31'd0, bus.mode}, {31'd0, opm[k]});
            if (w < 3) tick();
         end
         tick();
         chk("bb_gap", {31'd0, bus.ivalid}, 32'd0);
         bus.ovalid = 1'b1;
         bus.zeros  = opz[k];
         tick();
         bus.ovalid = 1'b0;
         chk("bb_res_valid", {31'd0, bus.res_valid}, 32'd1);
         chk("bb_res_zeros", {26'd0, bus.res_zeros}, {26'd0, opz[k]});
         chk("bb_res_err", {31'd0, bus.res_err}, 32'd0);
         tick();
      end
      bus.res_ready = 1'b0;
      chk("bb_space01", acc[1] - acc[0], 32'd7);
      chk("bb_space12", acc[2] - acc[1], 32'd7);
      chk("bb_end_idle", {31'd0, bus.in_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
